brq_rr: RTL

Parametrised bus request queue, the successor to the fixed 4-requester brq. N_REQ requesters post (sender ID, destination) entries through a round-robin arbiter, one enqueue per cycle, into a DEPTH-entry ordered queue. On the drain side, the oldest entry whose destination is free is offered to the bus controller. Younger entries may bypass a blocked head, limited by an anti-starvation cap. The block sits between the requesting units and the bus grant logic.

---
 rtl/brq_rr.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/brq_rr.sv
// brq_rr: parametrised bus request queue.
// N_REQ requesters post {send, dest} entries through a round-robin arbiter
// (one enqueue per cycle) into an ordered DEPTH-entry queue. The drain side
// offers the oldest entry whose destination is free. Younger entries may
// bypass a blocked head, but only AGE_MAX times in a row.
//
// Ports:
//   clk      clock, all state on posedge
//   clr      synchronous active-low reset
//   send     packed sender IDs, requester i at [i*ID_W +: ID_W]
//   dest     packed destination indices, requester i at [i*DEST_W +: DEST_W]
//   req      request strobes, held until ack
//   ack      one-hot combinational grant (cycle of enqueue)
//   free     destination-ready flags
//   pull     dequeue the selected entry at the next posedge
//   valid    an eligible entry is presented
//   empty    count == 0
//   full     count == DEPTH
//   send_out sender ID of the selected entry (0 when !valid)
//   dest_out destination of the selected entry (0 when !valid)
//   count    occupancy
module brq_rr #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 4,
  parameter int N_DEST  = 8,
  parameter int DEPTH   = 8,
  parameter int AGE_MAX = 3
) (
  input  logic                               clk,
  input  logic                               clr,
  input  logic [N_REQ*ID_W-1:0]              send,
  input  logic [N_REQ*$clog2(N_DEST)-1:0]    dest,
  input  logic [N_REQ-1:0]                   req,
  output logic [N_REQ-1:0]                   ack,
  input  logic [N_DEST-1:0]                  free,
  input  logic                               pull,
  output logic                               valid,
  output logic                               empty,
  output logic                               full,
  output logic [ID_W-1:0]                    send_out,
  output logic [$clog2(N_DEST)-1:0]          dest_out,
  output logic [$clog2(DEPTH+1)-1:0]         count
);

  localparam int DEST_W = $clog2(N_DEST);
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int RR_W   = $clog2(N_REQ);
  localparam int AGE_W  = $clog2(AGE_MAX+1);
  localparam int unsigned NR = N_REQ;

  logic [ID_W-1:0]   send_q [DEPTH];
  logic [DEST_W-1:0] dest_q [DEPTH];
  logic [CNT_W-1:0]  cnt_q;
  logic [RR_W-1:0]   rr_ptr;
  logic [AGE_W-1:0]  bypass_cnt;

  logic              gnt;
  logic [RR_W-1:0]   win;
  logic [ID_W-1:0]   enq_send;
  logic [DEST_W-1:0] enq_dest;
  logic              found;
  logic [IDX_W-1:0]  sel;
  logic              deq;
  logic [IDX_W-1:0]  wr_idx;

  assign count = cnt_q;
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));

  // Round-robin search starting at rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    int unsigned p;
    p        = 0;
    gnt      = 1'b0;
    win      = '0;
    ack      = '0;
    enq_send = '0;
    enq_dest = '0;
    if (clr && !full) begin
      for (int unsigned i = 0; i < NR; i++) begin
        p = 32'(rr_ptr) + i;
        if (p >= NR) p = p - NR;
        if (!gnt && req[RR_W'(p)]) begin
          gnt = 1'b1;
          win = RR_W'(p);
        end
      end
      if (gnt) ack[win] = 1'b1;
    end
    for (int unsigned i = 0; i < NR; i++) begin
      if (gnt && win == RR_W'(i)) begin
        enq_send = send[i*ID_W +: ID_W];
        enq_dest = dest[i*DEST_W +: DEST_W];
      end
    end
  end

  // Lowest eligible entry; once the bypass cap is hit only the head qualifies.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (!found && CNT_W'(k) < cnt_q && free[dest_q[IDX_W'(k)]] &&
          (k == 0 || bypass_cnt != AGE_W'(AGE_MAX))) begin
        found = 1'b1;
        sel   = IDX_W'(k);
      end
    end
  end

  assign valid    = found;
  assign send_out = found ? send_q[sel] : '0;
  assign dest_out = found ? dest_q[sel] : '0;
  assign deq      = clr && pull && found;
  // Compaction happens first, so a concurrent enqueue lands one slot lower.
  assign wr_idx   = IDX_W'(cnt_q - CNT_W'(deq));

  always_ff @(posedge clk) begin
    if (!clr) begin
      cnt_q      <= '0;
      rr_ptr     <= '0;
      bypass_cnt <= '0;
    end else begin
      if (deq) begin
        for (int unsigned k = 0; k < DEPTH-1; k++) begin
          if (IDX_W'(k) >= sel) begin
            send_q[IDX_W'(k)] <= send_q[IDX_W'(k+1)];
            dest_q[IDX_W'(k)] <= dest_q[IDX_W'(k+1)];
          end
        end
      end
      // Placed after the shift so the new entry overrides any shifted value.
      if (gnt) begin
        send_q[wr_idx] <= enq_send;
        dest_q[wr_idx] <= enq_dest;
        rr_ptr         <= (win == RR_W'(N_REQ-1)) ? '0 : win + 1'b1;
      end
      cnt_q <= cnt_q + CNT_W'(gnt) - CNT_W'(deq);
      if (deq) begin
        if (sel != '0) begin
          if (bypass_cnt != AGE_W'(AGE_MAX)) bypass_cnt <= bypass_cnt + 1'b1;
        end else begin
          bypass_cnt <= '0;
        end
      end else if (empty) begin
        bypass_cnt <= '0;
      end
    end
  end

endmodule
